// File: rtl/nandy_ctl_pkg.sv
// Shared definitions for the Nandy step controller: state encoding and
// the default number of clock phases per instruction.
package nandy_ctl_pkg;

    localparam int PHASES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BURST  = 2'd2,
        ST_HALTED = 2'd3
    } ctl_state_e;

endpackage

// File: rtl/phase_ring.sv
// Phase counter for one instruction: holds ph, flags the last phase and
// registers the one-hot edgegate enable for the phase that follows.
module phase_ring
    import nandy_ctl_pkg::*;
#(
    parameter int PHASES = PHASES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_advance,
    input  logic              i_clear,
    input  logic              i_gate,
    output logic              o_last,
    output logic [PHASES-1:0] o_gate_en
);

    localparam int PH_W = $clog2(PHASES);

    logic [PH_W-1:0]   r_ph;
    logic [PHASES-1:0] r_gate_en;
    logic [PH_W-1:0]   w_ph_nxt;
    logic [PHASES-1:0] w_oh_nxt;

    assign o_last = (r_ph == PH_W'(PHASES - 1));

    always_comb begin
        w_ph_nxt = r_ph;
        if (i_clear)
            w_ph_nxt = '0;
        else if (i_advance)
            w_ph_nxt = o_last ? '0 : r_ph + PH_W'(1);
    end

    // Decode the next phase so the enable lands in the same cycle as ph.
    always_comb begin
        w_oh_nxt = '0;
        for (int i = 0; i < PHASES; i++)
            w_oh_nxt[i] = (w_ph_nxt == PH_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph      <= '0;
            r_gate_en <= '0;
        end else begin
            r_ph      <= w_ph_nxt;
            r_gate_en <= i_gate ? w_oh_nxt : '0;
        end
    end

    assign o_gate_en = r_gate_en;

endmodule

// File: rtl/step_controller.sv
// Run / halt / single-step / burst sequencer for the Nandy edgegate bank.
// Execution only starts and stops on instruction boundaries.
module step_controller
    import nandy_ctl_pkg::*;
#(
    parameter int PHASES   = PHASES_DEF,
    parameter int BURST_W  = 8,
    parameter int ICOUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step_req,
    input  logic                burst_req,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic                cpu_halt,
    input  logic                resume,
    output logic [PHASES-1:0]   gate_en,
    output logic                instr_done,
    output logic                busy,
    output logic                halted,
    output logic [ICOUNT_W-1:0] instr_count
);

    ctl_state_e          r_state;
    logic [BURST_W-1:0]  r_remaining;
    logic [ICOUNT_W-1:0] r_instr_count;
    logic                r_instr_done;
    logic                r_busy;
    logic                r_halted;

    ctl_state_e w_state_nxt;
    logic       w_busy_cur;
    logic       w_busy_nxt;
    logic       w_last;
    logic       w_boundary;
    logic       w_burst_ok;

    assign w_busy_cur = (r_state == ST_RUN) || (r_state == ST_BURST);
    assign w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_BURST);
    assign w_boundary = w_busy_cur && w_last;
    assign w_burst_ok = burst_req && (burst_len != '0);

    phase_ring #(
        .PHASES (PHASES)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_busy_cur),
        .i_clear   (!w_busy_cur),
        .i_gate    (w_busy_nxt),
        .o_last    (w_last),
        .o_gate_en (gate_en)
    );

    // cpu_halt outranks every other exit because the CPU has already retired
    // its halt instruction by the time the boundary is reached.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run)
                    w_state_nxt = ST_RUN;
                else if (w_burst_ok || step_req)
                    w_state_nxt = ST_BURST;
            end
            ST_RUN: begin
                if (w_last) begin
                    if (cpu_halt)
                        w_state_nxt = ST_HALTED;
                    else if (!run)
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_last) begin
                    if (cpu_halt)
                        w_state_nxt = ST_HALTED;
                    else if (r_remaining == BURST_W'(1))
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (resume)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_instr_count <= '0;
            r_instr_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_halted     <= (w_state_nxt == ST_HALTED);
            r_instr_done <= w_boundary;

            if (w_boundary)
                r_instr_count <= r_instr_count + ICOUNT_W'(1);

            if (r_state == ST_IDLE && w_state_nxt == ST_BURST)
                r_remaining <= w_burst_ok ? burst_len : BURST_W'(1);
            else if (r_state == ST_BURST && w_last)
                r_remaining <= cpu_halt ? '0 : r_remaining - BURST_W'(1);
        end
    end

    assign instr_done  = r_instr_done;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign instr_count = r_instr_count;

endmodule
